imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that sits upstream of `top`. It receives a length-prefixed, checksummed byte stream, packs it into little-endian 32-bit instruction words and writes them into the instruction memory write port. It holds the pipeline core in reset until a load completes with a matching checksum, replacing direct `$readmemh` preloading with a synthesizable path that benches can also drive byte by byte.

## Interface
Parameters:
- `ADDR_W`, 10: instruction-memory word-address width; depth = 2**ADDR_W words.
- `BASE_ADDR`, 0: word address of the first loaded instruction.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: byte stream valid.
- `in_data`, in, 8: byte stream data.
- `in_ready`, out, 1: loader accepts a byte; transfer when `in_valid && in_ready`.
- `restart`, in, 1: one-cycle pulse that starts a new load from DONE or ERR.
- `imem_we`, out, 1: instruction memory write enable.
- `imem_addr`, out, ADDR_W: word address.
- `imem_wdata`, out, 32: instruction word.
- `core_rst`, out, 1: reset to `top`, active-high.
- `done`, out, 1: load completed and checksum matched.
- `err`, out, 1: load aborted.
- `err_code`, out, 2: 01 = length overflow, 10 = checksum mismatch, 00 = none.
- `words_loaded`, out, ADDR_W+1: number of words written in the current load.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N payload bytes with each word sent LSB first, then one checksum byte CK.
- CK must equal the sum mod 256 of every preceding byte, including the length bytes.
- FSM states: S_LEN0 → S_LEN1 → S_DATA → S_CKSUM → S_DONE | S_ERR.
- S_LEN0 and S_LEN1 capture the length bytes.
- After LEN_HI is accepted:
  - If N > 2**ADDR_W − BASE_ADDR, go to S_ERR with err_code 01.
  - Else if N == 0, go to S_CKSUM.
  - Otherwise go to S_DATA.
- S_DATA uses a 2-bit byte counter; the 4th byte of each word completes it.
  - Writes go to `BASE_ADDR + word_index`.
  - After word N completes, go to S_CKSUM.
- S_CKSUM: if CK matches, go to S_DONE; otherwise go to S_ERR with err_code 10.
- S_DONE and S_ERR hold until `restart` or `rst`.
  - On `restart`, go to S_LEN0: clear `done`/`err`/`err_code`/`words_loaded`/checksum, and set `core_rst` = 1.
  - `restart` is ignored in all other states.
- `in_ready` = 1 in S_LEN0..S_CKSUM, 0 in S_DONE and S_ERR. Bytes are never dropped while `in_ready` = 1.
- The running checksum is an 8-bit accumulator that wraps mod 256.

## Timing
- Reset values: state S_LEN0, `in_ready` 1, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `core_rst` 1, `done` 0, `err` 0, `err_code` 00, `words_loaded` 0.
- Write latency: `imem_we` is high for exactly one cycle, the cycle after the 4th byte of a word is accepted. `imem_addr`/`imem_wdata` are valid in that cycle, and `words_loaded` increments in that same cycle.
- The first byte of the next word may be accepted in the same cycle as the write pulse, so throughput is 1 byte/cycle with no bubbles.
- `done` rises and `core_rst` falls the cycle after an accepted matching CK.
- On a mismatching CK, `err` rises the cycle after; `core_rst` stays 1.
- On length overflow, `err` rises the cycle after LEN_HI is accepted; no writes occur.
- `rst` has priority over `restart` and over byte acceptance.
- `rst` mid-load returns all outputs to their reset values. Words already written stay in memory (no erase).
- Back-to-back loads: `restart` in S_DONE gives `in_ready` = 1 and `core_rst` = 1 on the next cycle.

## Structure
- Package `loader_pkg`: state enum `loader_state_t`, `ERR_NONE`/`ERR_OVERFLOW`/`ERR_CKSUM` constants.
- Sub-module `byte_packer`: shifts 4 bytes into a 32-bit little-endian word and emits a one-cycle `word_valid`.
- The FSM, address counter and checksum live in `imem_loader`.

## Test plan
- Nominal load: bytes 02 00 93 00 50 00 13 01 A0 00 99 → writes 0x00500093 @0 then 0x00A00113 @1. Then `done` = 1, `core_rst` = 0, `words_loaded` = 2, `in_ready` = 0.
- Bad checksum: same stream with CK = 98 → both words written, then `err` = 1, `err_code` = 10, `core_rst` stays 1.
- Zero length: 00 00 00 → no `imem_we`, then `done` = 1, `words_loaded` = 0.
- Overflow with ADDR_W = 2, N = 5: 05 00 → `err_code` = 01 the cycle after LEN_HI, `in_ready` = 0, no writes.
- `in_valid` toggling every other cycle during the nominal stream → identical writes and final state. Assert `rst` after byte 6 → outputs return to reset values, and a new full stream then loads correctly.
- `restart` after done, then stream 01 00 13 00 00 00 14 → 0x00000013 @0, `done` = 1 again. `restart` pulsed mid-S_DATA → no effect.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the FSM state encoding, the error codes and a capacity helper.
package loader_pkg;

    typedef enum logic [2:0] {
        S_LEN0  = 3'd0,
        S_LEN1  = 3'd1,
        S_DATA  = 3'd2,
        S_CKSUM = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } loader_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW = 2'b01;
    localparam logic [1:0] ERR_CKSUM    = 2'b10;

    // Number of words that fit between BASE_ADDR and the top of memory.
    function automatic logic [31:0] word_capacity(input int addr_w, input int base_addr);
        return 32'((1 << addr_w) - base_addr);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects four bytes (LSB first) into a 32-bit word and pulses word_valid
// for one cycle in the cycle after the fourth byte is taken.
module byte_packer (
    input  logic        clk,
    input  logic        srst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_cnt,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  cnt_reg;
    logic        word_valid_reg;
    logic [31:0] word_data_reg;
    logic [23:0] lanes;

    // Lanes 0..2 park the first three bytes; lane 3 goes straight into the word.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk) begin
                if (srst) begin
                    lane_reg <= 8'h00;
                end else if (byte_valid && (cnt_reg == 2'(gi))) begin
                    lane_reg <= byte_data;
                end
            end
            assign lanes[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg        <= 2'd0;
            word_valid_reg <= 1'b0;
            word_data_reg  <= 32'h0;
        end else begin
            word_valid_reg <= byte_valid && (cnt_reg == 2'd3);
            if (byte_valid) begin
                cnt_reg <= cnt_reg + 2'd1;
            end
            if (byte_valid && (cnt_reg == 2'd3)) begin
                word_data_reg <= {byte_data, lanes};
            end
        end
    end

    assign byte_cnt   = cnt_reg;
    assign word_valid = word_valid_reg;
    assign word_data  = word_data_reg;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte stream, writes the
// packed words into instruction memory and releases core reset on success.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0] CAPACITY = word_capacity(ADDR_W, BASE_ADDR);

    loader_state_t     state_reg, state_next;
    logic [7:0]        len_lo_reg, len_lo_next;
    logic [15:0]       len_reg, len_next;
    logic [7:0]        cksum_reg, cksum_next;
    logic [ADDR_W:0]   words_reg, words_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [1:0]        err_code_reg, err_code_next;

    logic              accept;
    logic [1:0]        byte_cnt;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   words_inc;

    assign in_ready  = (state_reg == S_LEN0) || (state_reg == S_LEN1) ||
                       (state_reg == S_DATA) || (state_reg == S_CKSUM);
    assign accept    = in_valid && in_ready;
    assign len_full  = {in_data, len_lo_reg};
    assign words_inc = words_reg + 1'b1;

    byte_packer u_packer (
        .clk        (clk),
        .srst       (rst),
        .byte_valid (accept && (state_reg == S_DATA)),
        .byte_data  (in_data),
        .byte_cnt   (byte_cnt),
        .word_valid (imem_we),
        .word_data  (imem_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_LEN0;
            len_lo_reg   <= 8'h00;
            len_reg      <= 16'h0000;
            cksum_reg    <= 8'h00;
            words_reg    <= '0;
            addr_reg     <= '0;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            len_lo_reg   <= len_lo_next;
            len_reg      <= len_next;
            cksum_reg    <= cksum_next;
            words_reg    <= words_next;
            addr_reg     <= addr_next;
            err_code_reg <= err_code_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        len_lo_next   = len_lo_reg;
        len_next      = len_reg;
        cksum_next    = cksum_reg;
        words_next    = words_reg;
        addr_next     = addr_reg;
        err_code_next = err_code_reg;

        case (state_reg)
            S_LEN0: begin
                if (accept) begin
                    len_lo_next = in_data;
                    cksum_next  = cksum_reg + in_data;
                    state_next  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_next   = len_full;
                    cksum_next = cksum_reg + in_data;
                    if (32'(len_full) > CAPACITY) begin
                        state_next    = S_ERR;
                        err_code_next = ERR_OVERFLOW;
                    end else if (len_full == 16'h0000) begin
                        state_next = S_CKSUM;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    cksum_next = cksum_reg + in_data;
                    // Address and count update together so they line up with imem_we.
                    if (byte_cnt == 2'd3) begin
                        words_next = words_inc;
                        addr_next  = ADDR_W'(BASE_ADDR) + words_reg[ADDR_W-1:0];
                        if (32'(words_inc) == 32'(len_reg)) begin
                            state_next = S_CKSUM;
                        end
                    end
                end
            end
            S_CKSUM: begin
                if (accept) begin
                    if (in_data == cksum_reg) begin
                        state_next = S_DONE;
                    end else begin
                        state_next    = S_ERR;
                        err_code_next = ERR_CKSUM;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    state_next    = S_LEN0;
                    len_lo_next   = 8'h00;
                    len_next      = 16'h0000;
                    cksum_next    = 8'h00;
                    words_next    = '0;
                    err_code_next = ERR_NONE;
                end
            end
            default: begin
                state_next = S_LEN0;
            end
        endcase
    end

    assign imem_addr    = addr_reg;
    assign done         = (state_reg == S_DONE);
    assign err          = (state_reg == S_ERR);
    assign core_rst     = (state_reg != S_DONE);
    assign err_code     = err_code_reg;
    assign words_loaded = words_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W = 2) with a write scoreboard.
// Expected writes are queued as streams are driven and popped on imem_we.
module tb_imem_loader;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              restart = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   words_loaded;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [ADDR_W:0]   wl;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stream_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .restart      (restart),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Scoreboard side: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {32'(imem_addr), imem_wdata}, 64'hDEAD);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(imem_addr), 64'(e.addr));
                check("wr_data", 64'(imem_wdata), 64'(e.data));
                check("wr_words_loaded", 64'(words_loaded), 64'(e.wl));
            end
        end
    end

    task automatic push_wr(input int a, input logic [31:0] d, input int wl);
        wr_t e;
        e.addr = ADDR_W'(a);
        e.data = d;
        e.wl   = (ADDR_W+1)'(wl);
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input int gap, input logic rs);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        restart  = rs;
        @(posedge clk);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            restart  = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic play(input int gap);
        foreach (stream_q[i]) send(stream_q[i], gap, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        restart  = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_in_ready", 64'(in_ready), 64'd1);
        check("restart_core_rst", 64'(core_rst), 64'd1);
        check("restart_done", 64'(done), 64'd0);
        check("restart_words", 64'(words_loaded), 64'd0);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
        check({pfx, "_imem_we"}, 64'(imem_we), 64'd0);
        check({pfx, "_imem_addr"}, 64'(imem_addr), 64'd0);
        check({pfx, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        check({pfx, "_core_rst"}, 64'(core_rst), 64'd1);
        check({pfx, "_done"}, 64'(done), 64'd0);
        check({pfx, "_err"}, 64'(err), 64'd0);
        check({pfx, "_err_code"}, 64'(err_code), 64'd0);
        check({pfx, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    task automatic check_final(input string pfx, input logic d, input logic e,
                               input logic [1:0] ec, input int wl);
        check({pfx, "_done"}, 64'(done), 64'(d));
        check({pfx, "_err"}, 64'(err), 64'(e));
        check({pfx, "_err_code"}, 64'(err_code), 64'(ec));
        check({pfx, "_core_rst"}, 64'(core_rst), 64'(!d));
        check({pfx, "_in_ready"}, 64'(in_ready), 64'd0);
        check({pfx, "_words"}, 64'(words_loaded), 64'(wl));
        check({pfx, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [7:0]  ck;
        logic [31:0] w;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("post_reset");
        $display("step reset done");

        // Nominal two-word load
        push_wr(0, 32'h00500093, 1);
        push_wr(1, 32'h00A00113, 2);
        stream_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                     8'h13, 8'h01, 8'hA0, 8'h00, 8'h99};
        play(0);
        check_final("nominal", 1'b1, 1'b0, 2'b00, 2);
        $display("step nominal load done");

        // Restart, one-word load, with restart pulsed mid-data (ignored)
        do_restart();
        push_wr(0, 32'h00000013, 1);
        send(8'h01, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        send(8'h13, 0, 1'b0);
        send(8'h00, 0, 1'b1);
        send(8'h00, 0, 1'b1);
        send(8'h00, 0, 1'b0);
        send(8'h14, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        restart  = 1'b0;
        check_final("one_word", 1'b1, 1'b0, 2'b00, 1);
        $display("step one-word load with mid-data restart done");

        // Bad checksum
        do_restart();
        push_wr(0, 32'h00500093, 1);
        push_wr(1, 32'h00A00113, 2);
        stream_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                     8'h13, 8'h01, 8'hA0, 8'h00, 8'h98};
        play(0);
        check_final("bad_cksum", 1'b0, 1'b1, 2'b10, 2);
        $display("step bad checksum done");

        // Zero length
        do_restart();
        stream_q = '{8'h00, 8'h00, 8'h00};
        play(0);
        check_final("zero_len", 1'b1, 1'b0, 2'b00, 0);
        $display("step zero length done");

        // Overflow: N = 5 with 4-word memory; further bytes are refused
        do_restart();
        stream_q = '{8'h05, 8'h00};
        play(0);
        check_final("overflow", 1'b0, 1'b1, 2'b01, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_final("overflow_hold", 1'b0, 1'b1, 2'b01, 0);
        $display("step overflow done");

        // Boundary: N equals capacity (4 words)
        do_restart();
        stream_q = '{8'h04, 8'h00};
        ck = 8'h04;
        for (int i = 0; i < 4; i++) begin
            w = 32'hA5C30000 | 32'(i * 32'h0101 + 7);
            push_wr(i, w, i + 1);
            for (int b = 0; b < 4; b++) begin
                stream_q.push_back(w[b*8 +: 8]);
                ck = ck + w[b*8 +: 8];
            end
        end
        stream_q.push_back(ck);
        play(0);
        check_final("full_depth", 1'b1, 1'b0, 2'b00, 4);
        $display("step full-depth load done");

        // Nominal stream with in_valid toggling every other cycle
        do_restart();
        push_wr(0, 32'h00500093, 1);
        push_wr(1, 32'h00A00113, 2);
        stream_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                     8'h13, 8'h01, 8'hA0, 8'h00, 8'h99};
        play(1);
        check_final("toggle", 1'b1, 1'b0, 2'b00, 2);
        $display("step gapped load done");

        // rst after byte 6 (first word completes), then a fresh full load
        do_restart();
        push_wr(0, 32'h00500093, 1);
        for (int i = 0; i < 6; i++) send(stream_q[i], 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_reset_values("mid_rst");
        rst = 1'b0;
        push_wr(0, 32'h00500093, 1);
        push_wr(1, 32'h00A00113, 2);
        play(0);
        check_final("reload", 1'b1, 1'b0, 2'b00, 2);
        $display("step mid-load reset and reload done");

        repeat (3) @(negedge clk);
        check("final_pending_writes", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
